// File: rtl/demux_dispatch.sv
// demux_dispatch
//   Feeds a 1-to-8 demux stage. One word from a valid/ready input stream is
//   registered and drives the demux data/select. Each word is sent to an
//   explicit channel or to the next round-robin channel. The word is held
//   until its channel is ready. If it waits too long, it is dropped.
//
// Ports
//   clk_i       in   clock, rising edge
//   rst_ni      in   synchronous active-low reset
//   in_valid_i  in   upstream word valid
//   in_ready_o  out  word can be accepted this cycle (combinational)
//   in_data_i   in   upstream data, N+1 bits
//   in_dest_i   in   explicit destination channel (mode_i = 0)
//   mode_i      in   0 = explicit destination, 1 = round-robin
//   ch_ready_i  in   per-channel consumer ready
//   data_o      out  registered data to the demux
//   sel_o       out  registered select to the demux
//   valid_o     out  a word is held
//   strobe_o    out  one-hot dispatch strobe (combinational)
//   drop_o      out  one-cycle pulse when a held word times out
module demux_dispatch #(
  parameter int N       = 3,
  parameter int TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N:0]   in_data_i,
  input  logic [2:0]   in_dest_i,
  input  logic         mode_i,
  input  logic [7:0]   ch_ready_i,
  output logic [N:0]   data_o,
  output logic [2:0]   sel_o,
  output logic         valid_o,
  output logic [7:0]   strobe_o,
  output logic         drop_o
);

  localparam int WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [N:0]          data_p0, data_d;
  logic [2:0]          sel_p0, sel_d;
  logic [2:0]          rr_p0, rr_d;
  logic [WCNT_W-1:0]   wcnt_p0, wcnt_d;
  logic                drop_p0, drop_d;
  logic                disp, acc, timeout_hit;

  // Wait counter sticks at all-ones rather than wrapping (only reachable
  // when the timeout is disabled).
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    return (&v) ? v : v + WCNT_W'(1);
  endfunction

  assign disp        = (state_q == HOLD) & ch_ready_i[sel_p0];
  assign in_ready_o  = rst_ni & ((state_q == IDLE) | disp);
  assign acc         = in_valid_i & in_ready_o;
  assign strobe_o    = (rst_ni & disp) ? (8'b1 << sel_p0) : 8'b0;
  // Dispatch has priority: a word whose channel becomes ready in the last
  // wait cycle is delivered, not dropped.
  assign timeout_hit = (TIMEOUT > 0) && (state_q == HOLD) && !disp && (wcnt_p0 == WCNT_LAST);

  always_comb begin
    state_d = state_q;
    data_d  = data_p0;
    sel_d   = sel_p0;
    rr_d    = rr_p0;
    wcnt_d  = wcnt_p0;
    drop_d  = 1'b0;
    if (acc) begin
      // A dispatch in the same cycle is replaced by the new word.
      state_d = HOLD;
      data_d  = in_data_i;
      sel_d   = mode_i ? rr_p0 : in_dest_i;
      wcnt_d  = '0;
      if (mode_i) rr_d = rr_p0 + 3'd1;
    end else if (disp) begin
      // Zero data so the demux outputs go quiet; select keeps its value.
      state_d = IDLE;
      data_d  = '0;
    end else if (timeout_hit) begin
      state_d = IDLE;
      data_d  = '0;
      drop_d  = 1'b1;
    end else if (state_q == HOLD) begin
      wcnt_d = sat_inc(wcnt_p0);
    end
  end

  // Stage p0: holding register feeding the demux
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_p0 <= '0;
      sel_p0  <= '0;
      rr_p0   <= '0;
      wcnt_p0 <= '0;
      drop_p0 <= 1'b0;
    end else begin
      state_q <= state_d;
      data_p0 <= data_d;
      sel_p0  <= sel_d;
      rr_p0   <= rr_d;
      wcnt_p0 <= wcnt_d;
      drop_p0 <= drop_d;
    end
  end

  assign data_o  = data_p0;
  assign sel_o   = sel_p0;
  assign valid_o = (state_q == HOLD);
  assign drop_o  = drop_p0;

endmodule

// File: tb/tb_demux_dispatch.sv
module tb_demux_dispatch;

  localparam int N       = 3;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [N:0] in_data_i;
  logic [2:0] in_dest_i;
  logic       mode_i;
  logic [7:0] ch_ready_i;
  logic [N:0] data_o;
  logic [2:0] sel_o;
  logic       valid_o;
  logic [7:0] strobe_o;
  logic       drop_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_dispatch #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_dest_i  (in_dest_i),
    .mode_i     (mode_i),
    .ch_ready_i (ch_ready_i),
    .data_o     (data_o),
    .sel_o      (sel_o),
    .valid_o    (valid_o),
    .strobe_o   (strobe_o),
    .drop_o     (drop_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni     = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_dest_i  = '0;
    mode_i     = 1'b0;
    ch_ready_i = 8'h00;

    // 1. reset
    #1;
    chk("rst_in_ready_comb", in_ready_o, 0);
    tick();
    tick();
    chk("rst_data", data_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_strobe", strobe_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready_o, 1);
    chk("post_rst_valid", valid_o, 0);

    // 2. explicit destination 5, data A
    in_valid_i = 1'b1; mode_i = 1'b0; in_dest_i = 3'd5; in_data_i = 4'hA; ch_ready_i = 8'hFF;
    tick();
    in_valid_i = 1'b0;
    #1;
    chk("exp_data", data_o, 4'hA);
    chk("exp_sel", sel_o, 5);
    chk("exp_valid", valid_o, 1);
    chk("exp_strobe", strobe_o, 8'h20);
    tick();
    chk("exp_after_valid", valid_o, 0);
    chk("exp_after_data", data_o, 0);
    chk("exp_after_sel", sel_o, 5);
    chk("exp_after_strobe", strobe_o, 0);

    // 3. ten back-to-back round-robin words
    mode_i = 1'b1; ch_ready_i = 8'hFF; in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data_i = 4'(i + 1);
      #1;
      chk("rr_in_ready", in_ready_o, 1);
      tick();
      chk("rr_sel", sel_o, i % 8);
      chk("rr_data", data_o, (i + 1) & 15);
      chk("rr_strobe", strobe_o, 1 << (i % 8));
    end
    in_valid_i = 1'b0;
    tick();
    chk("rr_end_valid", valid_o, 0);

    // 4. blocked word times out
    mode_i = 1'b0; in_dest_i = 3'd3; in_data_i = 4'h7; ch_ready_i = 8'hF7; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    #1;
    for (int c = 1; c <= 16; c++) begin
      chk("to_valid", valid_o, 1);
      chk("to_strobe", strobe_o, 0);
      chk("to_drop", drop_o, 0);
      chk("to_in_ready", in_ready_o, 0);
      tick();
    end
    chk("to_drop_pulse", drop_o, 1);
    chk("to_idle", valid_o, 0);
    chk("to_data_zero", data_o, 0);
    chk("to_drop_strobe", strobe_o, 0);
    chk("to_drop_in_ready", in_ready_o, 1);
    tick();
    chk("to_drop_once", drop_o, 0);

    // 5. channel ready in the last wait cycle: dispatch beats timeout
    in_dest_i = 3'd3; in_data_i = 4'h9; ch_ready_i = 8'hF7; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    #1;
    for (int c = 1; c <= 16; c++) begin
      if (c == 16) begin
        ch_ready_i = 8'h08;
        #1;
        chk("late_strobe", strobe_o, 8'h08);
        chk("late_in_ready", in_ready_o, 1);
      end else begin
        chk("late_wait_strobe", strobe_o, 0);
      end
      tick();
    end
    chk("late_no_drop", drop_o, 0);
    chk("late_idle", valid_o, 0);
    ch_ready_i = 8'h00;
    tick();
    chk("late_no_drop2", drop_o, 0);

    // 6. reset in the middle of a hold
    mode_i = 1'b1; in_data_i = 4'h5; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("mid_sel_rr2", sel_o, 2);
    tick();
    tick();
    chk("mid_valid_before", valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready_o, 0);
    chk("mid_rst_strobe", strobe_o, 0);
    tick();
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_drop", drop_o, 0);
    rst_ni = 1'b1;
    mode_i = 1'b1; in_data_i = 4'hC; ch_ready_i = 8'hFF; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    #1;
    chk("mid_rr_restart_sel", sel_o, 0);
    chk("mid_rr_restart_strobe", strobe_o, 8'h01);
    chk("mid_rr_restart_data", data_o, 4'hC);
    tick();
    chk("mid_no_drop", drop_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
